// File: rtl/approx_add_err_monitor.sv
// Error-statistics monitor for the approximate adder.
// Recomputes a+b, accumulates error distance over a sample window.
module approx_add_err_monitor #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_y,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] remaining;
  logic             s1_v;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH:0]   s1_y;
  logic             s2_v, s2_nz;
  logic [WIDTH:0]   s2_ed;
  logic             hs, clr;
  logic [WIDTH:0]   exact, ed;
  logic [ACC_W:0]   sum_ext;

  assign hs  = in_valid && in_ready;
  assign clr = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE:
        if (start) state_nx = (win_len != '0) ? RUN : DONE;
      RUN:
        if (hs && remaining == CNT_W'(1)) state_nx = DRAIN;
      DRAIN:
        if (!s1_v && s2_v) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      (state == RUN):   begin in_ready = 1'b1; busy = 1'b1; end
      (state == DRAIN): busy = 1'b1;
      (state == DONE):  done = 1'b1;
      default: ;
    endcase
  end

  assign exact = {1'b0, s1_a} + {1'b0, s1_b};
  assign ed    = (exact >= s1_y) ? exact - s1_y : s1_y - exact;
  assign sum_ext = {1'b0, sum_ed}
                 + {{(ACC_W - WIDTH){1'b0}}, s2_ed};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      s1_v      <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_y      <= '0;
      s2_v      <= 1'b0;
      s2_nz     <= 1'b0;
      s2_ed     <= '0;
    end else begin
      if (clr)     remaining <= win_len;
      else if (hs) remaining <= remaining - CNT_W'(1);
      s1_v <= hs;
      if (hs) begin
        s1_a <= in_a;
        s1_b <= in_b;
        s1_y <= in_y;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_ed <= ed;
        s2_nz <= (ed != '0);
      end
    end
  end

  // Stage 3: statistics; a start clears them on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
    end else begin
      if (hs) sample_cnt <= sample_cnt + CNT_W'(1);
      if (s2_v) begin
        err_cnt <= err_cnt + CNT_W'(s2_nz);
        if (s2_ed > max_ed) max_ed <= s2_ed;
        sum_ed <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_approx_add_err_monitor.sv
// Directed bench for approx_add_err_monitor.
// Hand-computed expectations, immediate assertions per check.
module tb_approx_add_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] win_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [32:0] in_y;
  logic        busy, done;
  logic [31:0] sample_cnt, err_cnt;
  logic [32:0] max_ed;
  logic [47:0] sum_ed;

  int checks = 0;
  int errors = 0;

  approx_add_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_y(in_y),
    .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .max_ed(max_ed), .sum_ed(sum_ed)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [32:0] y);
    in_valid = v;
    in_a = a;
    in_b = b;
    in_y = y;
  endtask

  task automatic pulse_start(input logic [31:0] len);
    start = 1'b1;
    win_len = len;
    step();
    start = 1'b0;
  endtask

  logic [19:0] pat;
  int          exp_hs;
  logic        exp_rdy;

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    win_len = '0;
    drive(1'b0, '0, '0, '0);
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_cnt", 64'(sample_cnt), 64'd0);
    chk("rst_sum", 64'(sum_ed), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // exact samples
    pulse_start(32'd4);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_rdy", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd1, 32'd2, 33'd3);                 step();
    drive(1'b1, 32'd100, 32'd200, 33'd300);           step();
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 33'h1_0000_0000); step();
    drive(1'b1, 32'd0, 32'd0, 33'd0);                 step();
    drive(1'b0, '0, '0, '0);
    chk("t1_rdy_drain", 64'(in_ready), 64'd0);
    chk("t1_done_k", 64'(done), 64'd0);
    step();
    chk("t1_done_k1", 64'(done), 64'd0);
    step();
    chk("t1_done_k2", 64'(done), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_cnt", 64'(sample_cnt), 64'd4);
    chk("t1_err", 64'(err_cnt), 64'd0);
    chk("t1_max", 64'(max_ed), 64'd0);
    chk("t1_sum", 64'(sum_ed), 64'd0);

    // error samples, restart from DONE, start ignored in RUN
    pulse_start(32'd3);
    chk("t2_clr_cnt", 64'(sample_cnt), 64'd0);
    chk("t2_run", 64'(in_ready), 64'd1);
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 33'd0); step();
    start = 1'b1;
    win_len = 32'd9;
    drive(1'b1, 32'd10, 32'd5, 33'd16); step();
    start = 1'b0;
    chk("t2_ign_cnt", 64'(sample_cnt), 64'd2);
    drive(1'b1, 32'd10, 32'd5, 33'd13); step();
    drive(1'b0, '0, '0, '0);
    chk("t2_rdy_drain", 64'(in_ready), 64'd0);
    step();
    step();
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_cnt", 64'(sample_cnt), 64'd3);
    chk("t2_err", 64'(err_cnt), 64'd3);
    chk("t2_max", 64'(max_ed), 64'h1_0000_0000);
    chk("t2_sum", 64'(sum_ed), 64'h1_0000_0003);

    // gapped in_valid; later samples are wrong to expose capture
    pulse_start(32'd3);
    pat = 20'b1101_1010_0111_0001_0101;
    exp_hs = 0;
    for (int i = 0; i < 20; i++) begin
      exp_rdy = (exp_hs < 3);
      if (exp_hs < 3) drive(pat[i], 32'(i), 32'(i), 33'(2 * i));
      else            drive(pat[i], 32'(i), 32'(i), 33'd0);
      chk("t3_rdy", 64'(in_ready), 64'(exp_rdy));
      if (pat[i] && exp_rdy) exp_hs++;
      step();
    end
    drive(1'b0, '0, '0, '0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_cnt", 64'(sample_cnt), 64'd3);
    chk("t3_err", 64'(err_cnt), 64'd0);
    chk("t3_sum", 64'(sum_ed), 64'd0);

    // zero window
    drive(1'b1, 32'd1, 32'd1, 33'd7);
    pulse_start(32'd0);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_cnt", 64'(sample_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_rdy", 64'(in_ready), 64'd0);
      step();
    end
    chk("t4_err", 64'(err_cnt), 64'd0);
    chk("t4_cnt2", 64'(sample_cnt), 64'd0);
    drive(1'b0, '0, '0, '0);

    // reset mid-window
    pulse_start(32'd5);
    drive(1'b1, 32'd4, 32'd4, 33'd9); step();
    drive(1'b1, 32'd4, 32'd4, 33'd6); step();
    drive(1'b1, 32'd1, 32'd1, 33'd0);
    step();
    step();
    chk("t5_pre_err", 64'(err_cnt), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rdy", 64'(in_ready), 64'd0);
    chk("t5_cnt", 64'(sample_cnt), 64'd0);
    chk("t5_err", 64'(err_cnt), 64'd0);
    chk("t5_max", 64'(max_ed), 64'd0);
    chk("t5_sum", 64'(sum_ed), 64'd0);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("t5_idle_cnt", 64'(sample_cnt), 64'd0);
    chk("t5_idle_err", 64'(err_cnt), 64'd0);
    chk("t5_idle_done", 64'(done), 64'd0);
    drive(1'b0, '0, '0, '0);
    pulse_start(32'd1);
    drive(1'b1, 32'd7, 32'd8, 33'd20); step();
    drive(1'b0, '0, '0, '0);
    step();
    step();
    chk("t5_new_done", 64'(done), 64'd1);
    chk("t5_new_cnt", 64'(sample_cnt), 64'd1);
    chk("t5_new_err", 64'(err_cnt), 64'd1);
    chk("t5_new_max", 64'(max_ed), 64'd5);
    chk("t5_new_sum", 64'(sum_ed), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
